// File: rtl/debayer_pkg.sv
// Shared types and constants for the debayer frame sequencer.
package debayer_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    localparam logic [1:0] RGGB = 2'd0;
    localparam logic [1:0] GRBG = 2'd1;
    localparam logic [1:0] GBRG = 2'd2;
    localparam logic [1:0] BGGR = 2'd3;

    localparam logic [15:0] MIN_DIM = 16'd2;
endpackage

// File: rtl/debayer_pos_cnt.sv
// x/y raster position counter; flags first pixel, end of line and end of frame.
module debayer_pos_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    input  logic        clr,
    input  logic [15:0] w,
    input  logic [15:0] h,
    output logic        x_lsb,
    output logic        y_lsb,
    output logic        sof,
    output logic        eol,
    output logic        eof
);
    logic [15:0] x_q, x_d, y_q, y_d;

    assign sof   = (x_q == 16'd0) && (y_q == 16'd0);
    assign eol   = (x_q == w - 16'd1);
    assign eof   = eol && (y_q == h - 16'd1);
    assign x_lsb = x_q[0];
    assign y_lsb = y_q[0];

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (adv) begin
            if (eof) begin
                x_d = '0;
                y_d = '0;
            end else if (eol) begin
                x_d = '0;
                y_d = y_q + 16'd1;
            end else begin
                x_d = x_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end
endmodule

// File: rtl/debayer_frame_ctrl.sv
// Frame sequencer ahead of the debayer datapath: gating, sideband tags, shadow config.
// Define DBR_TIMEOUT_EN to add the stall watchdog (TO_CYCLES) that aborts a hung frame.
module debayer_frame_ctrl #(
    parameter int DW        = 16,
    parameter int FRM_CW    = 16,
    parameter int TO_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       cfg_width,
    input  logic [15:0]       cfg_height,
    input  logic [1:0]        cfg_pattern,
    input  logic              cfg_oneshot,
    input  logic              start,
    input  logic              stop,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic [1:0]        out_phase,
    output logic              busy,
    output logic              frame_done,
    output logic [FRM_CW-1:0] frame_count,
    output logic              cfg_err,
    output logic              timeout_err
);
    import debayer_pkg::*;

    state_e            state_q, state_d;
    logic              stop_pend_q, stop_pend_d;
    logic [15:0]       w_q, w_d, h_q, h_d;
    logic [1:0]        pat_q, pat_d;
    logic              one_q, one_d;
    logic              fd_q, fd_d;
    logic [FRM_CW-1:0] cnt_q, cnt_d;
    logic              cerr_q, cerr_d;

    logic run, xfer, cfg_ok, abort_now, to_fire;
    logic x_lsb, y_lsb, sof, eol, eof;

    assign run    = (state_q == RUN);
    assign xfer   = run && in_valid && out_ready;
    assign cfg_ok = (cfg_width >= MIN_DIM) && (cfg_height >= MIN_DIM);
    assign abort_now = abort || to_fire;

    debayer_pos_cnt u_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (xfer),
        .clr   (abort_now),
        .w     (w_q),
        .h     (h_q),
        .x_lsb (x_lsb),
        .y_lsb (y_lsb),
        .sof   (sof),
        .eol   (eol),
        .eof   (eof)
    );

`ifdef DBR_TIMEOUT_EN
    localparam int STW = $clog2(TO_CYCLES + 1);
    logic [STW-1:0] stall_q, stall_d;
    logic           terr_q, terr_d;

    assign to_fire = run && (stall_q >= STW'(TO_CYCLES));
    assign stall_d = (run && !xfer && !abort_now) ? stall_q + STW'(1) : '0;
    assign terr_d  = terr_q || to_fire;
    assign timeout_err = terr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            stall_q <= stall_d;
            terr_q  <= terr_d;
        end
    end
`else
    assign to_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Outputs are forced quiet outside RUN so IDLE presents all-zero.
    assign in_ready    = run && out_ready;
    assign out_valid   = run && in_valid;
    assign out_data    = run ? in_data : '0;
    assign out_sof     = run && sof;
    assign out_eol     = run && eol;
    assign out_eof     = run && eof;
    assign out_phase   = run ? ({y_lsb, x_lsb} ^ pat_q) : 2'b00;
    assign busy        = run;
    assign frame_done  = fd_q;
    assign frame_count = cnt_q;
    assign cfg_err     = cerr_q;

    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        w_d         = w_q;
        h_d         = h_q;
        pat_d       = pat_q;
        one_d       = one_q;
        fd_d        = 1'b0;
        cnt_d       = cnt_q;
        cerr_d      = cerr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        w_d     = cfg_width;
                        h_d     = cfg_height;
                        pat_d   = cfg_pattern;
                        one_d   = cfg_oneshot;
                        state_d = RUN;
                    end else begin
                        cerr_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) stop_pend_d = 1'b1;
                if (xfer && eof) begin
                    fd_d  = 1'b1;
                    cnt_d = cnt_q + FRM_CW'(1);
                    if (stop_pend_q || one_q || stop) begin
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                    end else if (cfg_ok) begin
                        w_d   = cfg_width;
                        h_d   = cfg_height;
                        pat_d = cfg_pattern;
                        one_d = cfg_oneshot;
                    end else begin
                        cerr_d      = 1'b1;
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort discards the partial frame, including a coincident eof transfer.
        if (abort_now) begin
            state_d     = IDLE;
            stop_pend_d = 1'b0;
            fd_d        = 1'b0;
            cnt_d       = cnt_q;
            cerr_d      = cerr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            stop_pend_q <= 1'b0;
            w_q         <= '0;
            h_q         <= '0;
            pat_q       <= '0;
            one_q       <= 1'b0;
            fd_q        <= 1'b0;
            cnt_q       <= '0;
            cerr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
            w_q         <= w_d;
            h_q         <= h_d;
            pat_q       <= pat_d;
            one_q       <= one_d;
            fd_q        <= fd_d;
            cnt_q       <= cnt_d;
            cerr_q      <= cerr_d;
        end
    end
endmodule
